// File: rtl/scan_bist_pkg.sv
// -----------------------------------------------------------------------------
// scan_bist_pkg
// Shared definitions for the scan-chain shift-test controller:
//   - controller FSM state encoding
//   - 16-bit LFSR width, Fibonacci tap mask and default seed
//   - mismatch-counter width and saturation value
//   - single-step LFSR helper used by both pattern generators
// -----------------------------------------------------------------------------
package scan_bist_pkg;

  localparam int LFSR_W = 16;

  // Taps for x^16 + x^14 + x^13 + x^11 + 1, as state bits 15, 13, 12, 10.
  localparam logic [LFSR_W-1:0] LFSR_TAPS    = 16'hB400;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;

  localparam int              ERR_W   = 8;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FLUSH = 3'd1,
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    FIN   = 3'd4
  } state_t;

  // Fibonacci form: the parity of the tapped bits is shifted in at bit 0 and
  // the generated pattern bit is read from bit 0 of the current state.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr16_step.sv
// -----------------------------------------------------------------------------
// lfsr16_step
// One 16-bit Fibonacci LFSR pattern source. The controller instantiates it
// twice: once to generate the stimulus and once as the expected-data reference,
// so both produce the identical sequence offset only by when they are stepped.
//
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset, loads SEED
//   load     in   reload SEED (start of a run)
//   advance  in   step the LFSR by one bit
//   out_bit  out  current pattern bit (state bit 0)
// -----------------------------------------------------------------------------
module lfsr16_step
  import scan_bist_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic advance,
  output logic out_bit
);

  logic [LFSR_W-1:0] state;

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      state <= SEED;
    end else if (advance) begin
      state <= lfsr_next(state);
    end
  end

  assign out_bit = state[0];

endmodule

// File: rtl/scan_chain_bist.sv
// -----------------------------------------------------------------------------
// scan_chain_bist
// Shift-test controller for a serial chain of CHAIN_LEN flops. A run flushes
// the chain with zeros, shifts NBITS LFSR bits in, then drains with zeros.
// The chain output is compared against a second copy of the same LFSR that is
// stepped CHAIN_LEN cycles later, and mismatches are counted (saturating).
//
// Parameters:
//   CHAIN_LEN  flops in the chain under test (2..1024)
//   NBITS      pattern bits shifted and checked per run (>= 1)
//   SEED       non-zero LFSR seed, loaded on START
//
// Ports:
//   CLK      in   single clock for controller and chain
//   RST      in   synchronous active-high reset
//   START    in   one-cycle run request, honoured only when idle
//   SE       out  shift enable to the chain
//   SI       out  registered serial data into the chain
//   SO       in   serial data from the last chain flop
//   BUSY     out  run in progress (from the cycle after START through DONE)
//   DONE     out  one-cycle pulse at run completion
//   PASS     out  last run had no mismatches; valid from DONE to next START
//   ERR_CNT  out  mismatch count of the last run, saturating at 255
//
// Run timeline (cycle 1 = first cycle after START is accepted):
//   FLUSH  cycles 1 .. L
//   SHIFT  cycles L+1 .. L+N
//   DRAIN  cycles L+N+1 .. 2L+N
//   FIN    cycle 2L+N+1 (DONE)
//   check  cycles 2L+1 .. 2L+N (SI of cycle t arrives on SO at t+L)
// -----------------------------------------------------------------------------
module scan_chain_bist
  import scan_bist_pkg::*;
#(
  parameter int                CHAIN_LEN = 16,
  parameter int                NBITS     = 64,
  parameter logic [LFSR_W-1:0] SEED      = DEFAULT_SEED
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  output logic             SE,
  output logic             SI,
  input  logic             SO,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [ERR_W-1:0] ERR_CNT
);

  localparam int CNT_RANGE = (CHAIN_LEN > NBITS) ? CHAIN_LEN : NBITS;
  localparam int CNT_W     = $clog2(CNT_RANGE + 1);

  localparam logic [CNT_W-1:0] CL_VAL  = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] CL_LAST = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] NB_VAL  = CNT_W'(NBITS);
  localparam logic [CNT_W-1:0] NB_LAST = CNT_W'(NBITS - 1);

  state_t state, next_state;

  logic [CNT_W-1:0] ph_cnt;   // cycles spent in the current phase
  logic [CNT_W-1:0] lag_cnt;  // cycles since SHIFT entry, holds at CHAIN_LEN
  logic [CNT_W-1:0] chk_cnt;  // bits checked so far this run
  logic [ERR_W-1:0] err_cnt;
  logic [ERR_W-1:0] err_next;
  logic             pass_q;
  logic             si_q;

  logic accept;
  logic in_pattern;
  logic check_en;
  logic mismatch;
  logic chk_done;
  logic stim_bit;
  logic ref_bit;

  assign accept     = (state == IDLE) && START;
  assign in_pattern = (state == SHIFT) || (state == DRAIN);

  // The first stimulus bit left SI at SHIFT entry, so it is due on SO exactly
  // CHAIN_LEN cycles later; from then on one bit arrives per cycle.
  assign check_en = in_pattern && (lag_cnt == CL_VAL) && (chk_cnt != NB_VAL);
  assign mismatch = check_en && (SO != ref_bit);
  assign err_next = (mismatch && (err_cnt != ERR_MAX)) ? err_cnt + ERR_W'(1) : err_cnt;

  // True when the check-done count will have reached NBITS after this edge.
  assign chk_done = (chk_cnt == NB_VAL) || (check_en && (chk_cnt == NB_LAST));

  lfsr16_step #(.SEED(SEED)) u_stim (
    .clk     (CLK),
    .rst     (RST),
    .load    (accept),
    .advance (next_state == SHIFT),
    .out_bit (stim_bit)
  );

  lfsr16_step #(.SEED(SEED)) u_ref (
    .clk     (CLK),
    .rst     (RST),
    .load    (accept),
    .advance (check_en),
    .out_bit (ref_bit)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      ph_cnt  <= '0;
      lag_cnt <= '0;
      chk_cnt <= '0;
      err_cnt <= '0;
      pass_q  <= 1'b0;
      si_q    <= 1'b0;
    end else begin
      state <= next_state;

      // SI is registered: the bit for the next cycle is chosen from next_state.
      si_q <= (next_state == SHIFT) ? stim_bit : 1'b0;

      if ((next_state != state) || !SE) begin
        ph_cnt <= '0;
      end else if (ph_cnt != '1) begin
        ph_cnt <= ph_cnt + CNT_W'(1);
      end

      if (accept) begin
        lag_cnt <= '0;
        chk_cnt <= '0;
        err_cnt <= '0;
        pass_q  <= 1'b0;
      end else begin
        if (in_pattern && (lag_cnt != CL_VAL)) begin
          lag_cnt <= lag_cnt + CNT_W'(1);
        end
        if (check_en) begin
          chk_cnt <= chk_cnt + CNT_W'(1);
        end
        err_cnt <= err_next;
        if (next_state == FIN) begin
          pass_q <= (err_next == '0);
        end
      end
    end
  end

  // NOTE: every signal driven here gets a default before the case statement,
  // so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    SE         = 1'b0;
    BUSY       = 1'b1;
    DONE       = 1'b0;
    unique case (state)
      IDLE: begin
        BUSY = 1'b0;
        if (START) next_state = FLUSH;
      end
      FLUSH: begin
        SE = 1'b1;
        if (ph_cnt == CL_LAST) next_state = SHIFT;
      end
      SHIFT: begin
        SE = 1'b1;
        if (ph_cnt == NB_LAST) next_state = DRAIN;
      end
      DRAIN: begin
        SE = 1'b1;
        // The drain length and the check window end on the same cycle; the
        // check-done interlock keeps FIN from ever cutting a check short.
        if ((ph_cnt >= CL_LAST) && chk_done) next_state = FIN;
      end
      FIN: begin
        DONE       = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign SI      = si_q;
  assign PASS    = pass_q;
  assign ERR_CNT = err_cnt;

endmodule
